ebi_slave_port: RTL

FPGA-side responder for the MCU's multiplexed 16-bit EBI bus, the counterpart of the MCU that drives writes into the display memories. It synchronises the asynchronous ALE/WE/RE strobes into the `clk_100m` domain and latches the address phase. It issues one-cycle write and read strobes, with bank select, toward the OAM, sprite and palette memories inside `display_driver`, and drives read data back onto `EBI_AD` while RE is asserted.

---
 rtl/ebi_pkg.sv | 23 ++
 rtl/ebi_sync.sv | 30 +++
 rtl/ebi_slave_port.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/ebi_pkg.sv
// Shared types and widths for the MCU EBI slave port.
// Address/data/bank widths, synchroniser depth and FSM state encoding.
package ebi_pkg;

    localparam int EBI_AW          = 16;
    localparam int EBI_DW          = 16;
    localparam int EBI_BW          = 3;
    localparam int EBI_SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WRITE,
        RD_WAIT,
        RD_DRIVE
    } ebi_state_t;

    // Burst address step; wraps 0xFFFF -> 0x0000 naturally.
    function automatic logic [EBI_AW-1:0] ebi_addr_next(input logic [EBI_AW-1:0] a);
        return a + 1'b1;
    endfunction

endpackage

// File: rtl/ebi_sync.sv
// Two-flop synchroniser for asynchronous EBI inputs, with per-bit reset value.
// Strobes reset to idle-high, data to zero, so both groups stay cycle-aligned.
module ebi_sync
    import ebi_pkg::*;
#(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/ebi_slave_port.sv
// FPGA-side responder for the MCU's multiplexed 16-bit EBI bus: latches the
// address phase, issues one-cycle write/read strobes and drives read data back.
module ebi_slave_port
    import ebi_pkg::*;
#(
    parameter int AUTO_INC   = 1,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk_100m,
    input  logic              reset,
    inout  wire  [EBI_DW-1:0] EBI_AD,
    input  logic              EBI_ALE,
    input  logic              EBI_WE,
    input  logic              EBI_RE,
    input  logic [EBI_BW-1:0] bank_select,
    output logic [EBI_AW-1:0] bus_addr,
    output logic [EBI_BW-1:0] bus_bank,
    output logic [EBI_DW-1:0] bus_wdata,
    output logic              bus_we,
    output logic              bus_re,
    input  logic [EBI_DW-1:0] bus_rdata,
    output logic              protocol_err
);

    localparam logic [1:0] RD_LAT = 2'(RD_LATENCY);

    logic [2:0]               strb_s;
    logic [EBI_BW+EBI_DW-1:0] data_s;
    logic                     ale_s, we_s, re_s;
    logic [EBI_DW-1:0]        ad_s;
    logic [EBI_BW-1:0]        bank_s;

    ebi_sync #(
        .WIDTH   (3),
        .RST_VAL (3'b111)
    ) u_sync_strb (
        .clk_i (clk_100m),
        .rst_i (reset),
        .d_i   ({EBI_ALE, EBI_WE, EBI_RE}),
        .q_o   (strb_s)
    );

    ebi_sync #(
        .WIDTH   (EBI_BW + EBI_DW),
        .RST_VAL ('0)
    ) u_sync_data (
        .clk_i (clk_100m),
        .rst_i (reset),
        .d_i   ({bank_select, EBI_AD}),
        .q_o   (data_s)
    );

    assign {ale_s, we_s, re_s} = strb_s;
    assign {bank_s, ad_s}      = data_s;

    ebi_state_t        state_q;
    logic [EBI_AW-1:0] addr_q;
    logic [EBI_AW-1:0] addr_d;
    logic [EBI_BW-1:0] bank_q;
    logic [EBI_DW-1:0] wdata_q;
    logic [EBI_DW-1:0] rd_hold_q;
    logic              we_q;
    logic              re_q;
    logic              err_q;
    logic              err_wait_q;
    logic              inc_pend_q;
    logic [1:0]        lat_cnt_q;
    logic              err_d;
    logic              all_idle_d;
    logic              rd_oe;

    always_comb begin
        addr_d     = ebi_addr_next(addr_q);
        all_idle_d = ale_s & we_s & re_s;
        err_d      = (!we_s && !re_s) ||
                     (!ale_s && (state_q == WRITE || state_q == RD_WAIT ||
                                 state_q == RD_DRIVE));
    end

    // After an error the FSM parks in IDLE until every strobe is idle again,
    // so a still-low strobe cannot start a fresh transaction or re-pulse.
    always_ff @(posedge clk_100m or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            bank_q     <= '0;
            wdata_q    <= '0;
            rd_hold_q  <= '0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            err_q      <= 1'b0;
            err_wait_q <= 1'b0;
            inc_pend_q <= 1'b0;
            lat_cnt_q  <= '0;
        end else begin
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            err_q      <= 1'b0;
            inc_pend_q <= 1'b0;
            if (inc_pend_q) begin
                addr_q <= addr_d;
            end
            if (err_wait_q) begin
                state_q <= IDLE;
                if (all_idle_d) begin
                    err_wait_q <= 1'b0;
                end
            end else if (err_d) begin
                err_q      <= 1'b1;
                err_wait_q <= 1'b1;
                state_q    <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (!ale_s) begin
                            state_q <= ADDR;
                            addr_q  <= ad_s;
                            bank_q  <= bank_s;
                        end else if (!we_s) begin
                            state_q <= WRITE;
                            wdata_q <= ad_s;
                        end else if (!re_s) begin
                            state_q   <= RD_WAIT;
                            re_q      <= 1'b1;
                            lat_cnt_q <= '0;
                        end
                    end
                    ADDR: begin
                        if (!ale_s) begin
                            addr_q <= ad_s;
                            bank_q <= bank_s;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                    WRITE: begin
                        if (we_s) begin
                            we_q       <= 1'b1;
                            inc_pend_q <= (AUTO_INC != 0);
                            state_q    <= IDLE;
                        end else begin
                            wdata_q <= ad_s;
                        end
                    end
                    RD_WAIT: begin
                        if (lat_cnt_q == RD_LAT) begin
                            rd_hold_q <= bus_rdata;
                            state_q   <= RD_DRIVE;
                        end else begin
                            lat_cnt_q <= lat_cnt_q + 1'b1;
                        end
                    end
                    RD_DRIVE: begin
                        if (re_s) begin
                            state_q <= IDLE;
                            if (AUTO_INC != 0) begin
                                addr_q <= addr_d;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Raw RE gates the driver so the bus is released without synchroniser lag.
    assign rd_oe  = (state_q == RD_DRIVE) && !EBI_RE;
    assign EBI_AD = rd_oe ? rd_hold_q : 'z;

    assign bus_addr     = addr_q;
    assign bus_bank     = bank_q;
    assign bus_wdata    = wdata_q;
    assign bus_we       = we_q;
    assign bus_re       = re_q;
    assign protocol_err = err_q;

endmodule
